// File: rtl/mem_wait.sv
// Wait-state memory: single-port word array answering after WAIT_CYCLES busy cycles.
// Optional macro MEM_WAIT_INIT_EN preloads word i with the value i.
module mem_wait #(
    parameter int DATA_W = 64,
    parameter int DEPTH = 64,
    parameter int ADDR_W = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDRESS = '0,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   data_out,
    output logic                ready,
    output logic                err
);
    localparam int BYTES = DATA_W / 8;
    localparam int LSB = $clog2(BYTES);
    localparam int OFF_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nx;
    logic [7:0] cnt, cnt_nx;

`ifdef MEM_WAIT_INIT_EN
    function automatic logic [DEPTH*DATA_W-1:0] init_mem();
        logic [DEPTH*DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < DEPTH; i++) v[i*DATA_W +: DATA_W] = DATA_W'(i);
        return v;
    endfunction
    logic [DEPTH*DATA_W-1:0] mem = init_mem();
`else
    logic [DEPTH*DATA_W-1:0] mem;
`endif

    logic [OFF_W-1:0]  off, off_q, acc_off;
    logic [DATA_W-1:0] data_q, acc_data;
    logic [BYTES-1:0]  be_q, acc_be;
    logic              wr_q, acc_wr;
    logic              bad_q, acc_bad;
    logic              sel, bad, req, access;

    assign off = address[LSB +: OFF_W];
    assign sel = (address >> (LSB + OFF_W)) == BASE_ADDRESS;
    assign req = (mem_read || mem_write) && sel;
    assign bad = (mem_read && mem_write)
              || ((address & ADDR_W'(BYTES - 1)) != '0)
              || (int'(off) >= DEPTH);

    // With no wait states the access happens on the accepting edge itself
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        access   = 1'b0;
        acc_off  = off_q;
        acc_data = data_q;
        acc_be   = be_q;
        acc_wr   = wr_q;
        acc_bad  = bad_q;
        unique case (state)
            IDLE: begin
                acc_off  = off;
                acc_data = data_in;
                acc_be   = byte_en;
                acc_wr   = mem_write;
                acc_bad  = bad;
                if (req) begin
                    cnt_nx = 8'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_nx = DONE;
                        access   = 1'b1;
                    end else begin
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_nx = cnt - 8'd1;
                if (cnt <= 8'd1) begin
                    state_nx = DONE;
                    access   = 1'b1;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ready <= access;
            err   <= access && acc_bad;
            if (access && !acc_bad && !acc_wr)
                data_out <= mem[int'(acc_off)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            off_q  <= off;
            data_q <= data_in;
            be_q   <= byte_en;
            wr_q   <= mem_write;
            bad_q  <= bad;
        end
    end

    // Reset on the access edge aborts the write
    always_ff @(posedge clk) begin
        if (!reset && access && !acc_bad && acc_wr) begin
            for (int i = 0; i < BYTES; i++)
                if (acc_be[i])
                    mem[int'(acc_off)*DATA_W + 8*i +: 8] <= acc_data[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_mem_wait.sv
// Directed bench for mem_wait: two wait-state builds (2 and 0) on one clock.
module tb_mem_wait;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd   [2];
    logic        wr   [2];
    logic [63:0] addr [2];
    logic [63:0] din  [2];
    logic [7:0]  be   [2];
    logic [63:0] dout [2];
    logic        rdy  [2];
    logic        errs [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wait #(.WAIT_CYCLES(2)) u0 (
        .clk(clk), .reset(reset), .mem_read(rd[0]), .mem_write(wr[0]),
        .address(addr[0]), .data_in(din[0]), .byte_en(be[0]),
        .data_out(dout[0]), .ready(rdy[0]), .err(errs[0])
    );

    mem_wait #(.WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .mem_read(rd[1]), .mem_write(wr[1]),
        .address(addr[1]), .data_in(din[1]), .byte_en(be[1]),
        .data_out(dout[1]), .ready(rdy[1]), .err(errs[1])
    );

    typedef struct {
        logic        r;
        logic        w;
        logic [63:0] a;
        logic [63:0] d;
        logic [7:0]  b;
        logic        e;
        logic [63:0] q;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic access(input int d, input logic r, input logic w,
                          input logic [63:0] a, input logic [63:0] dn,
                          input logic [7:0] b, output int lat,
                          output logic e, output logic [63:0] q);
        @(negedge clk);
        rd[d] = r; wr[d] = w; addr[d] = a; din[d] = dn; be[d] = b;
        @(posedge clk); #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
        lat = 1;
        while (!rdy[d] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = errs[d];
        q = dout[d];
        @(posedge clk); #1;
        chk("ready_pulse_width", 64'(rdy[d]), 64'd0);
    endtask

    initial begin
        int lat;
        logic e;
        logic [63:0] q;
        string nm;

        vecs[0]  = '{1'b0, 1'b1, 64'h08,  64'd1, 8'hFF, 1'b0, 64'd0};
        vecs[1]  = '{1'b0, 1'b1, 64'h10,  64'd2, 8'hFF, 1'b0, 64'd0};
        vecs[2]  = '{1'b0, 1'b1, 64'h18,  64'd3, 8'hFF, 1'b0, 64'd0};
        vecs[3]  = '{1'b0, 1'b1, 64'h20,  64'd4, 8'hFF, 1'b0, 64'd0};
        vecs[4]  = '{1'b1, 1'b0, 64'h18,  64'd0, 8'h00, 1'b0, 64'd3};
        vecs[5]  = '{1'b0, 1'b1, 64'h20,  64'h1122334455667788, 8'h0F, 1'b0, 64'd3};
        vecs[6]  = '{1'b1, 1'b0, 64'h20,  64'd0, 8'h00, 1'b0, 64'h0000000055667788};
        vecs[7]  = '{1'b1, 1'b0, 64'h1C,  64'd0, 8'h00, 1'b1, 64'h0000000055667788};
        vecs[8]  = '{1'b1, 1'b1, 64'h08,  64'hDEAD, 8'hFF, 1'b1, 64'h0000000055667788};
        vecs[9]  = '{1'b1, 1'b0, 64'h08,  64'd0, 8'h00, 1'b0, 64'd1};
        vecs[10] = '{1'b0, 1'b1, 64'h20,  64'hFFFFFFFFFFFFFFFF, 8'h81, 1'b0, 64'd1};
        vecs[11] = '{1'b1, 1'b0, 64'h20,  64'd0, 8'h00, 1'b0, 64'hFF000000556677FF};
        vecs[12] = '{1'b0, 1'b1, 64'h1F8, 64'h5A, 8'hFF, 1'b0, 64'hFF000000556677FF};
        vecs[13] = '{1'b1, 1'b0, 64'h1F8, 64'd0, 8'h00, 1'b0, 64'h5A};
        vecs[14] = '{1'b0, 1'b1, 64'h21,  64'd0, 8'hFF, 1'b1, 64'h5A};
        vecs[15] = '{1'b1, 1'b0, 64'h20,  64'd0, 8'h00, 1'b0, 64'hFF000000556677FF};

        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; din[d] = '0; be[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ready%0d", d), 64'(rdy[d]), 64'd0);
            chk($sformatf("reset_err%0d", d), 64'(errs[d]), 64'd0);
            chk($sformatf("reset_dout%0d", d), dout[d], 64'd0);
        end

        for (int i = 0; i < 16; i++) begin
            access(0, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b, lat, e, q);
            nm = $sformatf("vec%0d", i);
            chk({nm, "_latency"}, 64'(lat), 64'd3);
            chk({nm, "_err"}, 64'(e), 64'(vecs[i].e));
            chk({nm, "_dout"}, q, vecs[i].q);
        end

        // requests held through BUSY and DONE must be ignored
        @(negedge clk);
        rd[0] = 1'b1; addr[0] = 64'h08;
        @(posedge clk); #1;
        rd[0] = 1'b0; wr[0] = 1'b1; din[0] = 64'h77; be[0] = 8'hFF;
        lat = 1;
        while (!rdy[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_ignore_latency", 64'(lat), 64'd3);
        chk("busy_ignore_dout", dout[0], 64'd1);
        @(posedge clk); #1;
        wr[0] = 1'b0;
        chk("busy_ignore_no_ready", 64'(rdy[0]), 64'd0);
        access(0, 1'b1, 1'b0, 64'h08, 64'd0, 8'h00, lat, e, q);
        chk("busy_ignore_readback", q, 64'd1);

        // reset during BUSY aborts a write
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 64'h10; din[0] = 64'h99; be[0] = 8'hFF;
        @(posedge clk); #1;
        wr[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        e = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            e = e | rdy[0];
        end
        chk("abort_no_ready", 64'(e), 64'd0);
        chk("abort_dout_reset", dout[0], 64'd0);
        access(0, 1'b1, 1'b0, 64'h10, 64'd0, 8'h00, lat, e, q);
        chk("abort_readback", q, 64'd2);

        // zero wait states: unselected address, then in-range accesses
        @(negedge clk);
        rd[1] = 1'b1; addr[1] = 64'h200;
        e = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            e = e | rdy[1];
        end
        rd[1] = 1'b0;
        chk("unselected_no_ready", 64'(e), 64'd0);
        access(1, 1'b0, 1'b1, 64'h08, 64'h42, 8'hFF, lat, e, q);
        chk("w0_write_latency", 64'(lat), 64'd1);
        access(1, 1'b1, 1'b0, 64'h08, 64'd0, 8'h00, lat, e, q);
        chk("w0_read_latency", 64'(lat), 64'd1);
        chk("w0_read_err", 64'(e), 64'd0);
        chk("w0_read_dout", q, 64'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
